// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colours, board packing, start position
// and the FSM state type used by board_controller.
package chess_pkg;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    localparam int NUM_SQ = 64;
    localparam int SQ_W   = 4;

    // Back rank with column 0 in the least significant slot.
    localparam logic [23:0] BACK_RANK = {PIECE_ROOK, PIECE_KNIGHT, PIECE_BISHOP, PIECE_KING,
                                         PIECE_QUEEN, PIECE_BISHOP, PIECE_KNIGHT, PIECE_ROOK};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_MOVE     = 2'd2
    } fsm_state_t;

    function automatic logic [255:0] board_init_f();
        logic [255:0] b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[(0 * 8 + c) * SQ_W +: SQ_W] = {COLOR_BLACK, BACK_RANK[c * 3 +: 3]};
            b[(1 * 8 + c) * SQ_W +: SQ_W] = {COLOR_BLACK, PIECE_PAWN};
            b[(6 * 8 + c) * SQ_W +: SQ_W] = {COLOR_WHITE, PIECE_PAWN};
            b[(7 * 8 + c) * SQ_W +: SQ_W] = {COLOR_WHITE, BACK_RANK[c * 3 +: 3]};
        end
        return b;
    endfunction

    localparam logic [255:0] BOARD_INIT = board_init_f();

    // A pawn reaching the far rank for its colour becomes a queen of that colour.
    function automatic logic [3:0] promote(input logic [3:0] piece, input logic [2:0] dst_row);
        logic far_rank;
        far_rank = (piece[3] == COLOR_WHITE) ? (dst_row == 3'd0) : (dst_row == 3'd7);
        if (piece[2:0] == PIECE_PAWN && far_rank)
            return {piece[3], PIECE_QUEEN};
        return piece;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for N debounced button lanes. History resets to 1 so a
// button already held when reset is released does not produce a pulse.
module btn_edge_detect #(
    parameter int N = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_btn,
    output logic [N-1:0] o_rise
);

    logic [N-1:0] r_hist;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_hist <= '1;
        else
            r_hist <= i_btn;
    end

    assign o_rise = i_btn & ~r_hist;

endmodule

// File: rtl/board_controller.sv
// Game-state stage feeding the display: board register, cursor and the
// IDLE/SELECTED/MOVE selection FSM. All outputs come straight from registers.
module board_controller
    import chess_pkg::*;
#(
    parameter logic       INIT_TURN = 1'b0,
    parameter logic [5:0] CUR_INIT  = 6'd52,
    parameter logic       WRAP_EN   = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_SELECT,
    output logic [255:0] BOARD,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         TURN,
    output logic         MOVE_DONE,
    output logic [1:0]   o_dbg_state
);

    logic [4:0] w_rise;
    logic       w_up, w_down, w_left, w_right, w_sel;

    btn_edge_detect #(.N(5)) u_edge (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_btn   ({BTN_SELECT, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP}),
        .o_rise  (w_rise)
    );

    assign w_up    = w_rise[0];
    assign w_down  = w_rise[1];
    assign w_left  = w_rise[2];
    assign w_right = w_rise[3];
    assign w_sel   = w_rise[4];

    logic [3:0]  r_board [NUM_SQ];
    fsm_state_t  r_state;
    logic [5:0]  r_cursor;
    logic [5:0]  r_sel;
    logic [5:0]  r_dst;
    logic        r_sel_en;
    logic        r_turn;
    logic        r_move_done;

    function automatic logic [2:0] dec3(input logic [2:0] v);
        return (v == 3'd0 && !WRAP_EN) ? v : v - 3'd1;
    endfunction

    function automatic logic [2:0] inc3(input logic [2:0] v);
        return (v == 3'd7 && !WRAP_EN) ? v : v + 3'd1;
    endfunction

    // Only the highest-priority direction edge moves the cursor.
    logic [2:0] w_row, w_col;
    logic [5:0] w_cursor_nxt;

    always_comb begin
        w_row = r_cursor[5:3];
        w_col = r_cursor[2:0];
        if (w_up)
            w_row = dec3(r_cursor[5:3]);
        else if (w_down)
            w_row = inc3(r_cursor[5:3]);
        else if (w_left)
            w_col = dec3(r_cursor[2:0]);
        else if (w_right)
            w_col = inc3(r_cursor[2:0]);
        w_cursor_nxt = {w_row, w_col};
    end

    logic [3:0] w_sq;
    logic       w_own;
    logic [3:0] w_moved;

    assign w_sq    = r_board[r_cursor];
    assign w_own   = (w_sq[2:0] != PIECE_NONE) && (w_sq[3] == r_turn);
    assign w_moved = promote(r_board[r_sel], r_dst[5:3]);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_SQ; i++)
                r_board[i] <= BOARD_INIT[i * SQ_W +: SQ_W];
            r_state     <= ST_IDLE;
            r_cursor    <= CUR_INIT;
            r_sel       <= '0;
            r_dst       <= '0;
            r_sel_en    <= 1'b0;
            r_turn      <= INIT_TURN;
            r_move_done <= 1'b0;
        end else begin
            r_cursor    <= w_cursor_nxt;
            r_move_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel && w_own) begin
                        r_sel    <= r_cursor;
                        r_sel_en <= 1'b1;
                        r_state  <= ST_SELECTED;
                    end
                end
                ST_SELECTED: begin
                    if (w_sel) begin
                        if (r_cursor == r_sel) begin
                            r_sel_en <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else if (w_own) begin
                            r_sel <= r_cursor;
                        end else begin
                            r_dst   <= r_cursor;
                            r_state <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    // Source and destination always differ: equal squares cancel instead.
                    r_board[r_dst] <= w_moved;
                    r_board[r_sel] <= '0;
                    r_turn         <= ~r_turn;
                    r_sel_en       <= 1'b0;
                    r_move_done    <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SQ; g++) begin : g_flat
        assign BOARD[g * SQ_W +: SQ_W] = r_board[g];
    end

    assign CURSOR_ADDR = r_cursor;
    assign SELECT_ADDR = r_sel;
    assign SELECT_EN   = r_sel_en;
    assign TURN        = r_turn;
    assign MOVE_DONE   = r_move_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: one wrapping and one saturating instance
// share the buttons; vector table plus hand-written reset-in-MOVE sequence.
module tb_board_controller;

    localparam logic [4:0] B_UP = 5'b00001;
    localparam logic [4:0] B_DN = 5'b00010;
    localparam logic [4:0] B_LT = 5'b00100;
    localparam logic [4:0] B_RT = 5'b01000;
    localparam logic [4:0] B_SL = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;

    logic [255:0] w_board, s_board;
    logic [5:0]   w_cur, s_cur, w_sel, s_sel;
    logic         w_en, s_en, w_turn, s_turn, w_done, s_done;
    logic [1:0]   w_dbg, s_dbg;

    int checks = 0;
    int errors = 0;

    board_controller #(.INIT_TURN(1'b0), .CUR_INIT(6'd52), .WRAP_EN(1'b1)) u_wrap (
        .CLK(clk), .RESET(rst_n),
        .BTN_UP(btn[0]), .BTN_DOWN(btn[1]), .BTN_LEFT(btn[2]), .BTN_RIGHT(btn[3]), .BTN_SELECT(btn[4]),
        .BOARD(w_board), .CURSOR_ADDR(w_cur), .SELECT_ADDR(w_sel), .SELECT_EN(w_en),
        .TURN(w_turn), .MOVE_DONE(w_done), .o_dbg_state(w_dbg)
    );

    board_controller #(.INIT_TURN(1'b0), .CUR_INIT(6'd52), .WRAP_EN(1'b0)) u_sat (
        .CLK(clk), .RESET(rst_n),
        .BTN_UP(btn[0]), .BTN_DOWN(btn[1]), .BTN_LEFT(btn[2]), .BTN_RIGHT(btn[3]), .BTN_SELECT(btn[4]),
        .BOARD(s_board), .CURSOR_ADDR(s_cur), .SELECT_ADDR(s_sel), .SELECT_EN(s_en),
        .TURN(s_turn), .MOVE_DONE(s_done), .o_dbg_state(s_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    typedef struct {
        logic [4:0] mask;
        int         hold;
        logic [5:0] cur_w;
        logic [5:0] cur_s;
        logic       en;
        logic [5:0] sel;
        logic       turn;
        logic       done;
        logic [5:0] sq_a;
        logic [3:0] val_a;
        logic [5:0] sq_b;
        logic [3:0] val_b;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [255:0] exp_init();
        logic [255:0] b;
        int back [8];
        back = '{4, 2, 3, 5, 6, 3, 2, 4};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[c * 4 +: 4]        = 4'(8 + back[c]);
            b[(8 + c) * 4 +: 4]  = 4'h9;
            b[(48 + c) * 4 +: 4] = 4'h1;
            b[(56 + c) * 4 +: 4] = 4'(back[c]);
        end
        return b;
    endfunction

    function automatic logic [3:0] get_sq(input logic [255:0] b, input logic [5:0] s);
        return b[s * 4 +: 4];
    endfunction

    function automatic vec_t mv(input logic [4:0] m, input int h, input logic [5:0] cw,
                                input logic [5:0] cs, input logic en, input logic [5:0] sel,
                                input logic turn);
        vec_t v;
        v.mask = m; v.hold = h; v.cur_w = cw; v.cur_s = cs; v.en = en; v.sel = sel;
        v.turn = turn; v.done = 1'b0;
        v.sq_a = '0; v.val_a = '0; v.sq_b = '0; v.val_b = '0;
        return v;
    endfunction

    // A SELECT that completes a move: checks the pulse and both touched squares.
    function automatic vec_t mvd(input logic [5:0] cur, input logic turn, input logic [5:0] sa,
                                 input logic [3:0] va, input logic [5:0] sb, input logic [3:0] vb);
        vec_t v;
        v = mv(B_SL, 1, cur, cur, 1'b0, 6'd0, turn);
        v.done = 1'b1;
        v.sq_a = sa; v.val_a = va; v.sq_b = sb; v.val_b = vb;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        btn = v.mask;
        repeat (v.hold) @(negedge clk);
        btn = '0;
        @(negedge clk);
        check($sformatf("v%0d cursor_wrap", idx), 256'(w_cur), 256'(v.cur_w));
        check($sformatf("v%0d cursor_sat", idx), 256'(s_cur), 256'(v.cur_s));
        check($sformatf("v%0d select_en", idx), 256'(w_en), 256'(v.en));
        if (v.en)
            check($sformatf("v%0d select_addr", idx), 256'(w_sel), 256'(v.sel));
        check($sformatf("v%0d turn", idx), 256'(w_turn), 256'(v.turn));
        check($sformatf("v%0d move_done", idx), 256'(w_done), 256'(v.done));
        if (v.done) begin
            check($sformatf("v%0d dst_square", idx), 256'(get_sq(w_board, v.sq_a)), 256'(v.val_a));
            check($sformatf("v%0d src_square", idx), 256'(get_sq(w_board, v.sq_b)), 256'(v.val_b));
            @(negedge clk);
            check($sformatf("v%0d move_done_drop", idx), 256'(w_done), 256'(0));
        end
    endtask

    int b_start;

    initial begin
        // Cursor walk: wrap vs saturate, priority, held button.
        vecs.push_back(mv(B_UP | B_RT, 1, 44, 44, 0, 0, 0));
        vecs.push_back(mv(B_DN, 1, 52, 52, 0, 0, 0));
        vecs.push_back(mv(B_LT, 10, 51, 51, 0, 0, 0));
        vecs.push_back(mv(B_RT, 1, 52, 52, 0, 0, 0));
        vecs.push_back(mv(B_DN, 1, 60, 60, 0, 0, 0));
        vecs.push_back(mv(B_LT, 1, 59, 59, 0, 0, 0));
        vecs.push_back(mv(B_LT, 1, 58, 58, 0, 0, 0));
        vecs.push_back(mv(B_LT, 1, 57, 57, 0, 0, 0));
        vecs.push_back(mv(B_LT, 1, 56, 56, 0, 0, 0));
        vecs.push_back(mv(B_LT, 1, 63, 56, 0, 0, 0));
        vecs.push_back(mv(B_DN, 1, 7, 56, 0, 0, 0));
        vecs.push_back(mv(B_UP, 1, 63, 48, 0, 0, 0));
        vecs.push_back(mv(B_RT, 1, 56, 49, 0, 0, 0));
        b_start = vecs.size();
        // Selection, reselect, cancel, moves, capture and promotion.
        vecs.push_back(mv(B_SL, 1, 52, 52, 1, 52, 0));
        vecs.push_back(mv(B_LT, 1, 51, 51, 1, 52, 0));
        vecs.push_back(mv(B_SL, 1, 51, 51, 1, 51, 0));
        vecs.push_back(mv(B_SL, 1, 51, 51, 0, 0, 0));
        vecs.push_back(mv(B_RT, 1, 52, 52, 0, 0, 0));
        vecs.push_back(mv(B_SL, 1, 52, 52, 1, 52, 0));
        vecs.push_back(mv(B_UP, 1, 44, 44, 1, 52, 0));
        vecs.push_back(mv(B_UP, 1, 36, 36, 1, 52, 0));
        vecs.push_back(mvd(36, 1, 36, 4'h1, 52, 4'h0));
        vecs.push_back(mv(B_UP, 1, 28, 28, 0, 0, 1));
        vecs.push_back(mv(B_UP, 1, 20, 20, 0, 0, 1));
        vecs.push_back(mv(B_UP, 1, 12, 12, 0, 0, 1));
        vecs.push_back(mv(B_SL, 1, 12, 12, 1, 12, 1));
        vecs.push_back(mv(B_DN, 1, 20, 20, 1, 12, 1));
        vecs.push_back(mvd(20, 0, 20, 4'h9, 12, 4'h0));
        vecs.push_back(mv(B_SL, 1, 20, 20, 0, 0, 0));
        vecs.push_back(mv(B_DN, 1, 28, 28, 0, 0, 0));
        vecs.push_back(mv(B_DN, 1, 36, 36, 0, 0, 0));
        vecs.push_back(mv(B_SL, 1, 36, 36, 1, 36, 0));
        vecs.push_back(mv(B_UP, 1, 28, 28, 1, 36, 0));
        vecs.push_back(mv(B_UP, 1, 20, 20, 1, 36, 0));
        vecs.push_back(mv(B_UP, 1, 12, 12, 1, 36, 0));
        vecs.push_back(mv(B_LT, 1, 11, 11, 1, 36, 0));
        vecs.push_back(mv(B_LT, 1, 10, 10, 1, 36, 0));
        vecs.push_back(mv(B_LT, 1, 9, 9, 1, 36, 0));
        vecs.push_back(mv(B_LT, 1, 8, 8, 1, 36, 0));
        vecs.push_back(mvd(8, 1, 8, 4'h1, 36, 4'h0));
        vecs.push_back(mv(B_RT, 1, 9, 9, 0, 0, 1));
        vecs.push_back(mv(B_SL, 1, 9, 9, 1, 9, 1));
        vecs.push_back(mv(B_DN, 1, 17, 17, 1, 9, 1));
        vecs.push_back(mvd(17, 0, 17, 4'h9, 9, 4'h0));
        vecs.push_back(mv(B_UP, 1, 9, 9, 0, 0, 0));
        vecs.push_back(mv(B_LT, 1, 8, 8, 0, 0, 0));
        vecs.push_back(mv(B_SL, 1, 8, 8, 1, 8, 0));
        vecs.push_back(mv(B_UP, 1, 0, 0, 1, 8, 0));
        vecs.push_back(mvd(0, 1, 0, 4'h5, 8, 4'h0));

        // Reset state with all buttons low.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset board_wrap", w_board, exp_init());
        check("reset board_sat", s_board, exp_init());
        check("reset sq0 black rook", 256'(w_board[3:0]), 256'(4'hC));
        check("reset sq52 white pawn", 256'(w_board[211:208]), 256'(4'h1));
        check("reset cursor", 256'({w_cur, s_cur}), 256'({6'd52, 6'd52}));
        check("reset select", 256'({w_en, w_sel, s_en, s_sel}), 256'(0));
        check("reset turn", 256'({w_turn, s_turn}), 256'(0));
        check("reset move_done", 256'({w_done, s_done}), 256'(0));
        check("reset fsm", 256'({w_dbg, s_dbg}), 256'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == b_start)
                do_reset();
            apply(vecs[i], i);
        end

        // Reset asserted during the MOVE cycle discards the move.
        do_reset();
        apply(mv(B_SL, 1, 52, 52, 1, 52, 0), 100);
        apply(mv(B_UP, 1, 44, 44, 1, 52, 0), 101);
        apply(mv(B_UP, 1, 36, 36, 1, 52, 0), 102);
        @(negedge clk);
        btn = B_SL;
        @(negedge clk);
        btn = '0;
        check("midmove fsm in MOVE", 256'(w_dbg), 256'(2));
        rst_n = 1'b0;
        @(negedge clk);
        check("midmove move_done", 256'(w_done), 256'(0));
        check("midmove board", w_board, exp_init());
        check("midmove select_en", 256'(w_en), 256'(0));
        check("midmove turn", 256'(w_turn), 256'(0));
        check("midmove cursor", 256'(w_cur), 256'(52));
        rst_n = 1'b1;
        @(negedge clk);
        check("midmove move_done after", 256'(w_done), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
